// File: rtl/vga_timing.sv
// VGA raster timing: pixel strobe, h/v counters, active-low syncs, active window and coordinates.
// Define VGA_TIMING_OUTREG_EN to register every output (including pix_stb) through one clk stage.
module vga_timing #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_stb,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]       HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             stb;

    // With CLK_DIV=1 the divider is a constant 0 and the strobe is permanently high.
    assign stb = (div_q == DIV_LAST);

    always_comb begin
        div_d = stb ? '0 : div_q + DIV_ONE;
        h_d   = h_q;
        v_d   = v_q;
        if (stb) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    logic       act_c, hs_c, vs_c, fs_c;
    logic [9:0] x_c;
    logic [8:0] y_c;

    always_comb begin
        act_c = (h_q < H_ACT) && (v_q < V_ACT);
        hs_c  = !((h_q >= HS_BEG) && (h_q < HS_END));
        vs_c  = !((v_q >= VS_BEG) && (v_q < VS_END));
        fs_c  = (h_q == '0) && (v_q == '0);
        x_c   = act_c ? h_q : '0;
        y_c   = act_c ? v_q[8:0] : '0;
    end

`ifdef VGA_TIMING_OUTREG_EN
    logic       stb_q, act_q, hs_q, vs_q, fs_q;
    logic [9:0] x_q;
    logic [8:0] y_q;

    // pix_stb goes through the same stage so it still marks the last clk of each delayed pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            act_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            stb_q <= stb;
            x_q   <= x_c;
            y_q   <= y_c;
            act_q <= act_c;
            hs_q  <= hs_c;
            vs_q  <= vs_c;
            fs_q  <= fs_c;
        end
    end

    assign pix_stb     = stb_q;
    assign x           = x_q;
    assign y           = y_q;
    assign active      = act_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;
`else
    assign pix_stb     = stb;
    assign x           = x_c;
    assign y           = y_c;
    assign active      = act_c;
    assign hsync       = hs_c;
    assign vsync       = vs_c;
    assign frame_start = fs_c;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default 640x480 line timing, CLK_DIV=1 line period,
// and full-frame behaviour on a shrunken raster so a frame fits in a short run.
module tb_vga_timing;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_c = 1'b1;

    logic       stb_a, act_a, hs_a, vs_a, fs_a;
    logic [9:0] x_a;
    logic [8:0] y_a;
    logic       stb_b, act_b, hs_b, vs_b, fs_b;
    logic [9:0] x_b;
    logic [8:0] y_b;
    logic       stb_c, act_c, hs_c, vs_c, fs_c;
    logic [9:0] x_c;
    logic [8:0] y_c;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    vga_timing u_a (
        .clk(clk), .rst(rst), .pix_stb(stb_a), .x(x_a), .y(y_a), .active(act_a),
        .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_timing #(.CLK_DIV(1)) u_b (
        .clk(clk), .rst(rst), .pix_stb(stb_b), .x(x_b), .y(y_b), .active(act_b),
        .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    // 15 pixels x 10 lines, 2 clk per pixel: frame = 300 clk.
    vga_timing #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_c (
        .clk(clk), .rst(rst_c), .pix_stb(stb_c), .x(x_c), .y(y_c), .active(act_c),
        .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int p, pc, n;
        int first_stb, last_stb, bad_gap, hs_low_clk, hs_first, hs_last;
        int x0, x1, x2, x639, act639, x640, y640, act640, x800, y800, act800;
        int b_zero, b_f1, b_f2;
        int r1, r2, fs_hi, ybad, vs_px, vs_first, vs_last, act_px;
        logic hs_b_prev, fs_c_prev;

        p = 0; pc = 0;
        first_stb = -1; last_stb = 0; bad_gap = 0;
        hs_low_clk = 0; hs_first = -1; hs_last = -1;
        x0 = -1; x1 = -1; x2 = -1; x639 = -1; act639 = -1;
        x640 = -1; y640 = -1; act640 = -1; x800 = -1; y800 = -1; act800 = -1;
        b_zero = 0; b_f1 = -1; b_f2 = -1;
        r1 = -1; r2 = -1; fs_hi = 0; ybad = 0; vs_px = 0; vs_first = -1; vs_last = -1; act_px = 0;
        hs_b_prev = 1'b1;
        fs_c_prev = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk_eq("rst_pix_stb", stb_a, 0);
        chk_eq("rst_x", x_a, 0);
        chk_eq("rst_y", y_a, 0);
        chk_eq("rst_active", act_a, 1);
        chk_eq("rst_hsync", hs_a, 1);
        chk_eq("rst_vsync", vs_a, 1);
        chk_eq("rst_frame_start", fs_a, 1);
        chk_eq("rst_pix_stb_div1", stb_b, 1);
        chk_eq("rst_pix_stb_div2", stb_c, 0);

        rst   = 1'b0;
        rst_c = 1'b0;

        for (int k = 1; k <= 3220; k++) begin
            @(negedge clk);
            if (!hs_a) hs_low_clk++;
            if (stb_a) begin
                if (first_stb < 0) first_stb = k + 1;
                else if (k - last_stb != 4) bad_gap++;
                last_stb = k;
                if (p == 0) x0 = int'(x_a);
                if (p == 1) x1 = int'(x_a);
                if (p == 2) x2 = int'(x_a);
                if (p == 639) begin x639 = int'(x_a); act639 = int'(act_a); end
                if (p == 640) begin x640 = int'(x_a); y640 = int'(y_a); act640 = int'(act_a); end
                if (p == 800) begin x800 = int'(x_a); y800 = int'(y_a); act800 = int'(act_a); end
                if (!hs_a) begin
                    if (hs_first < 0) hs_first = p;
                    hs_last = p;
                end
                p++;
            end

            if (!stb_b) b_zero++;
            if (hs_b_prev && !hs_b) begin
                if (b_f1 < 0) b_f1 = k;
                else if (b_f2 < 0) b_f2 = k;
            end
            hs_b_prev = hs_b;

            if (fs_c && !fs_c_prev) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
            if (fs_c && r1 >= 0 && r2 < 0) fs_hi++;
            fs_c_prev = fs_c;
            if (act_c && y_c > 9'd5) ybad++;
            if (stb_c) begin
                if (pc < 150) begin
                    if (!vs_c) begin
                        vs_px++;
                        if (vs_first < 0) vs_first = pc;
                        vs_last = pc;
                    end
                    if (act_c) act_px++;
                end
                pc++;
            end
        end

        chk_eq("first_stb_edge", first_stb, 4);
        chk_eq("stb_gap_errors", bad_gap, 0);
        chk_eq("x_pix0", x0, 0);
        chk_eq("x_pix1", x1, 1);
        chk_eq("x_pix2", x2, 2);
        chk_eq("x_pix639", x639, 639);
        chk_eq("active_pix639", act639, 1);
        chk_eq("active_pix640", act640, 0);
        chk_eq("x_pix640", x640, 0);
        chk_eq("y_pix640", y640, 0);
        chk_eq("hsync_low_clks", hs_low_clk, 384);
        chk_eq("hsync_first_px", hs_first, 656);
        chk_eq("hsync_last_px", hs_last, 751);
        chk_eq("x_line1_pix0", x800, 0);
        chk_eq("y_line1_pix0", y800, 1);
        chk_eq("active_line1_pix0", act800, 1);

        chk_eq("div1_stb_low_clks", b_zero, 0);
        chk_eq("div1_hsync_first_fall", b_f1, 656);
        chk_eq("div1_line_period", b_f2 - b_f1, 800);

        chk_eq("small_frame_start_rise", r1, 300);
        chk_eq("small_frame_period", r2 - r1, 300);
        chk_eq("small_frame_start_width", fs_hi, 2);
        chk_eq("small_vsync_low_px", vs_px, 30);
        chk_eq("small_vsync_first_px", vs_first, 105);
        chk_eq("small_vsync_last_px", vs_last, 134);
        chk_eq("small_active_px", act_px, 48);
        chk_eq("small_active_y_range", ybad, 0);

        n = 0;
        while (!(stb_a && x_a == 10'd300 && y_a == 9'd1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_eq("seek_h300_v1", (n < 3000) ? 1 : 0, 1);

        rst = 1'b1;
        #1;
        chk_eq("midrst_pix_stb", stb_a, 0);
        chk_eq("midrst_x", x_a, 0);
        chk_eq("midrst_y", y_a, 0);
        chk_eq("midrst_active", act_a, 1);
        chk_eq("midrst_hsync", hs_a, 1);
        chk_eq("midrst_vsync", vs_a, 1);
        chk_eq("midrst_frame_start", fs_a, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        first_stb = -1;
        for (int k = 1; k <= 12 && first_stb < 0; k++) begin
            @(negedge clk);
            if (stb_a) begin
                first_stb = k + 1;
                x0 = int'(x_a);
                y640 = int'(y_a);
            end
        end
        chk_eq("midrst_first_stb_edge", first_stb, 4);
        chk_eq("midrst_restart_x", x0, 0);
        chk_eq("midrst_restart_y", y640, 0);
        repeat (4) @(negedge clk);
        chk_eq("midrst_next_stb", stb_a, 1);
        chk_eq("midrst_next_x", x_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
